// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// mux_sel_sequencer : latches a word and sweeps an 8:1 mux select 0..7, LSB first
// Optional build macro: MUX_SEQ_LOOP_EN (continuous back-to-back sweeps)
// Revision: 1.0
// ============================================================================
module mux_sel_sequencer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] load_data,
  output logic [7:0] data,
  output logic [2:0] sel,
  output logic       en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic       r_en, w_en_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= 8'h00;
      r_hold  <= 8'h00;
      r_sel   <= 3'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_hold  <= w_hold_nxt;
      r_sel   <= w_sel_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_hold_nxt  = r_hold;
    w_sel_nxt   = r_sel;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_en_nxt   = 1'b0;
        w_sel_nxt  = 3'd0;
        w_busy_nxt = 1'b0;
        w_hold_nxt = 8'h00;
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          w_data_nxt  = load_data;
          w_en_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          w_en_nxt    = 1'b0;
          w_sel_nxt   = 3'd0;
          w_busy_nxt  = 1'b0;
          w_hold_nxt  = 8'h00;
          w_state_nxt = IDLE;
        end else if (r_hold < c_HOLD_LAST) begin
          w_hold_nxt = r_hold + 8'd1;
        end else if (r_sel != 3'd7) begin
          w_sel_nxt  = r_sel + 3'd1;
          w_hold_nxt = 8'h00;
        end else begin
          w_hold_nxt = 8'h00;
          w_sel_nxt  = 3'd0;
          w_done_nxt = 1'b1;
`ifdef MUX_SEQ_LOOP_EN
          // a held start at the final expiry chains straight into a fresh sweep
          if (start) begin
            w_data_nxt = load_data;
          end else begin
            w_en_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = DONE;
          end
`else
          w_en_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = DONE;
`endif
        end
      end

      DONE: begin
        w_en_nxt    = 1'b0;
        w_sel_nxt   = 3'd0;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = 8'h00;
        w_state_nxt = IDLE;
      end

      default: begin
        w_en_nxt    = 1'b0;
        w_sel_nxt   = 3'd0;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = 8'h00;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data = r_data;
  assign sel  = r_sel;
  assign en   = r_en;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mux_sel_sequencer : directed bench for mux_sel_sequencer (HOLD_CYCLES 1 and 3)
// Revision: 1.0
// ============================================================================
module tb_mux_sel_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [7:0] load1 = 8'h00;
  logic [7:0] data1;
  logic [2:0] sel1;
  logic       en1, busy1, done1;

  logic       start3 = 1'b0, abort3 = 1'b0;
  logic [7:0] load3 = 8'h00;
  logic [7:0] data3;
  logic [2:0] sel3;
  logic       en3, busy3, done3;

  int checks   = 0;
  int failures = 0;

  // observed vectors: {data, sel, en, busy, done}
  logic [13:0] obs1, obs3;
  assign obs1 = {data1, sel1, en1, busy1, done1};
  assign obs3 = {data3, sel3, en3, busy3, done3};

  always #5 clk = ~clk;

  mux_sel_sequencer #(.HOLD_CYCLES(1)) u_hold1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .load_data(load1),
    .data(data1), .sel(sel1), .en(en1), .busy(busy1), .done(done1)
  );

  mux_sel_sequencer #(.HOLD_CYCLES(3)) u_hold3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .load_data(load3),
    .data(data3), .sel(sel3), .en(en3), .busy(busy3), .done(done3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    exp = 14'h0;
    rst = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (obs1 !== exp) begin
        failures++;
        $display("FAIL reset_h1 observed=%h required=%h", obs1, exp);
      end
      checks++;
      if (obs3 !== exp) begin
        failures++;
        $display("FAIL reset_h3 observed=%h required=%h", obs3, exp);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_first_sweep();
    logic [13:0] exp;
    load1  = 8'b1010_1010;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {8'hAA, 3'(k), 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs1 !== exp) begin
        failures++;
        $display("FAIL sweep1_k%0d observed=%h required=%h", k, obs1, exp);
      end
      step();
    end
    exp = {8'hAA, 3'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs1 !== exp) begin
      failures++;
      $display("FAIL sweep1_done observed=%h required=%h", obs1, exp);
    end
    step();
    exp = {8'hAA, 3'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs1 !== exp) begin
      failures++;
      $display("FAIL sweep1_idle observed=%h required=%h", obs1, exp);
    end
  endtask

  task automatic test_hold_timing();
    logic [13:0] exp;
    load3  = 8'h5C;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      exp = {8'h5C, 3'(k / 3), 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs3 !== exp) begin
        failures++;
        $display("FAIL hold3_k%0d observed=%h required=%h", k, obs3, exp);
      end
      step();
    end
    exp = {8'h5C, 3'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL hold3_done observed=%h required=%h", obs3, exp);
    end
    step();
    exp = {8'h5C, 3'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL hold3_idle observed=%h required=%h", obs3, exp);
    end
  endtask

  task automatic test_abort();
    logic [13:0] exp;
    load3  = 8'h5C;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    repeat (12) step();
    exp = {8'h5C, 3'd4, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL abort_pre observed=%h required=%h", obs3, exp);
    end
    abort3 = 1'b1;
    step();
    abort3 = 1'b0;
    exp = {8'h5C, 3'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL abort_post observed=%h required=%h", obs3, exp);
    end
    step();
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL abort_nodone observed=%h required=%h", obs3, exp);
    end
    load3  = 8'h3C;
    start3 = 1'b1;
    step();
    exp = {8'h3C, 3'd0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL abort_restart observed=%h required=%h", obs3, exp);
    end
  endtask

  // continues the sweep started at the end of test_abort, start still high
  task automatic test_start_ignored();
    logic [13:0] exp;
    load3 = 8'hFF;
    for (int k = 1; k < 24; k++) begin
      step();
      if (k == 23) start3 = 1'b0;
      exp = {8'h3C, 3'(k / 3), 1'b1, 1'b1, 1'b0};
      checks++;
      if (obs3 !== exp) begin
        failures++;
        $display("FAIL busy_ign_k%0d observed=%h required=%h", k, obs3, exp);
      end
    end
    step();
    exp = {8'h3C, 3'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL busy_ign_done observed=%h required=%h", obs3, exp);
    end
    start3 = 1'b1;
    step();
    exp = {8'h3C, 3'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL done_start_ign observed=%h required=%h", obs3, exp);
    end
    abort3 = 1'b1;
    step();
    start3 = 1'b0;
    abort3 = 1'b0;
    checks++;
    if (obs3 !== exp) begin
      failures++;
      $display("FAIL collision observed=%h required=%h", obs3, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] exp;
    load1  = 8'h99;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (5) step();
    exp = {8'h99, 3'd5, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs1 !== exp) begin
      failures++;
      $display("FAIL areset_pre observed=%h required=%h", obs1, exp);
    end
    #2;
    rst = 1'b1;
    #1;
    exp = 14'h0;
    checks++;
    if (obs1 !== exp) begin
      failures++;
      $display("FAIL areset_now observed=%h required=%h", obs1, exp);
    end
    rst = 1'b0;
    step();
  endtask

`ifdef MUX_SEQ_LOOP_EN
  task automatic test_loop();
    logic [13:0] exp;
    load1  = 8'h0F;
    start1 = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      if (k == 7) load1 = 8'hF0;
      if (k == 15) start1 = 1'b0;
      exp = {(k < 8) ? 8'h0F : 8'hF0, 3'(k % 8), 1'b1, 1'b1, (k == 8) ? 1'b1 : 1'b0};
      checks++;
      if (obs1 !== exp) begin
        failures++;
        $display("FAIL loop_k%0d observed=%h required=%h", k, obs1, exp);
      end
      step();
    end
    exp = {8'hF0, 3'd0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs1 !== exp) begin
      failures++;
      $display("FAIL loop_end observed=%h required=%h", obs1, exp);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_first_sweep();
    test_hold_timing();
    test_abort();
    test_start_ignored();
    test_async_reset();
`ifdef MUX_SEQ_LOOP_EN
    test_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream driver for the lab's 8:1 multiplexer stage. Owns the 8-bit data word, select and enable inputs of that mux.
- On a start request it latches an 8-bit word, asserts enable and sweeps the 3-bit select from 0 to 7.
- Each select value is held for a programmable number of clock cycles, so the downstream mux serialises the word LSB-first.
- Provides busy/done status, plus an abort input for early termination.

Parameters:
HOLD_CYCLES, 1, clock cycles each select value is held; legal range 1..255; 8-bit internal hold counter.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled on rising clk edge
abort  input  1  terminate the current sweep; sampled on rising clk edge
load_data  input  8  word captured on an accepted start
data  output  8  registered word driven to the mux data input
sel  output  3  registered select driven to the mux select input
en  output  1  registered mux enable
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse on normal sweep completion

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- All outputs are registered.
- Reset values, applied immediately on rst assertion at any time, including mid-sweep:
  - data=8'h00, sel=3'b000, en=0, busy=0, done=0.
  - FSM goes to IDLE; hold counter goes to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - en=0, sel=0, busy=0, done=0; data keeps its last captured word.
  - start=1 and abort=0 at an edge: data<=load_data, sel<=0, en<=1, busy<=1, hold counter<=0, go to RUN. Outputs are valid the cycle after that edge (latency 1).
  - start=1 and abort=1 together: abort wins; stay in IDLE, no capture.
- RUN, each edge:
  - If abort=1: en<=0, sel<=0, busy<=0, go to IDLE. done is not pulsed.
  - Else if hold counter < HOLD_CYCLES-1: increment the hold counter only.
  - Else if sel < 7: sel<=sel+1 and hold counter<=0.
  - Else (sel=7 and hold expired): en<=0, sel<=0, busy<=0, done<=1, go to DONE.
- Sweep length: en stays high for exactly 8*HOLD_CYCLES cycles. Each sel value 0..7 is held exactly HOLD_CYCLES cycles. sel never exceeds 7 and never wraps while in RUN.
- While in RUN, start is ignored and load_data changes are ignored; data stays stable for the whole sweep.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE with done<=0.
  - start during the DONE cycle is ignored.
  - A new start is accepted from IDLE, i.e. earliest 2 edges after the final sweep edge.
- HOLD_CYCLES=1: sel advances every cycle. The hold counter is always 0 and the compare is still correct.
- An abort on the same edge as the final sel=7 expiry wins: no done pulse.

Optional Feature:
MUX_SEQ_LOOP_EN
- Defined (continuous mode): at the sel=7 hold expiry with start=1 and abort=0:
  - data<=load_data (fresh capture), sel<=0, hold counter<=0.
  - en and busy stay 1 and the FSM stays in RUN.
  - done pulses for that one cycle.
  - With start=0 at that edge, behaviour is the normal DONE path.
- Undefined: start during RUN is always ignored, and every sweep ends via DONE/IDLE.

Test Plan:
- Reset and first sweep: rst high 3 cycles then low, HOLD_CYCLES=1, load_data=8'b10101010, start pulsed one cycle. Required:
  - all outputs 0 during reset;
  - next cycle data=8'hAA, en=1, sel=0; sel steps 0..7 on consecutive cycles, en high 8 cycles;
  - then done=1 for 1 cycle, en=0, sel=0, busy=0.
- Hold timing: HOLD_CYCLES=3, load_data=8'h5C, start. Required: each sel value held exactly 3 cycles, en high 24 cycles, one done pulse.
- Abort mid-sweep: abort asserted when sel=4. Required:
  - next cycle en=0, sel=0, busy=0, done never asserted;
  - data still 8'h5C;
  - a start 2 cycles later captures the new load_data.
- Start ignored while busy and on collision: start held high and load_data changed to 8'hFF during RUN. Required: data unchanged and no restart until IDLE. start+abort together in IDLE: no capture, en stays 0.
- Async reset mid-sweep: rst asserted between clock edges at sel=5. Required: en, sel, data, busy, done drop to 0 immediately, not at the next edge.
- Loop mode (MUX_SEQ_LOOP_EN defined): start held high, load_data=8'h0F then 8'hF0 at the first wrap. Required: en stays high 16 cycles continuously, done pulses at the wrap, and the second sweep drives data=8'hF0.
